// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, func3 codes and request legality check for the unified-memory arbiter.
// Pure declarations: no latency, no flow control of its own.
package mem_arb_pkg;

   localparam int ADDR_W_DEF        = 11;
   localparam int MEM_AW_DEF        = 13;
   localparam int DATA_BASE_DEF     = 2048;
   localparam int MAX_DM_STREAK_DEF = 4;

   typedef enum logic [1:0] {IDLE, CMD, RESP, ERR} state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned widths exist only for loads; stores accept B/H/W.
   function automatic bit is_legal(input logic we, input logic [2:0] func3,
                                   input logic [1:0] addr_lo);
      bit ok;
      ok = 1'b0;
      case (func3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~addr_lo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF/DM) and memory-side signal bundle; slave = arbiter, master = environment.
// Wires only: latency and backpressure are owned by the arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int MEM_AW = 13
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_valid;
   logic              if_err;
   logic [31:0]       if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [2:0]        dm_func3;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic              dm_valid;
   logic              dm_err;
   logic [31:0]       dm_rdata;

   logic              mem_rd;
   logic              mem_wr;
   logic [2:0]        mem_func3;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_func3, dm_addr, dm_wdata, mem_rdata,
      output if_valid, if_err, if_rdata, dm_valid, dm_err, dm_rdata,
             mem_rd, mem_wr, mem_func3, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_func3, dm_addr, dm_wdata, mem_rdata,
      input  if_valid, if_err, if_rdata, dm_valid, dm_err, dm_rdata,
             mem_rd, mem_wr, mem_func3, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter_load_extend.sv
// Load data extension by func3 (byte/half sign or zero, word pass-through); illegal codes give 0.
// Combinational, zero latency, no backpressure.
module load_extend
   import mem_arb_pkg::*;
(
   input  logic [31:0] raw_i,
   input  logic [2:0]  func3_i,
   output logic [31:0] ext_o
);
   always_comb begin
      ext_o = '0;
      case (func3_i)
         F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
         F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
         F3_W:    ext_o = raw_i;
         F3_BU:   ext_o = {24'd0, raw_i[7:0]};
         F3_HU:   ext_o = {16'd0, raw_i[15:0]};
         default: ext_o = '0;
      endcase
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Time-shares one memory port between fetch and data with DM priority bounded by a streak limit.
// Legal access: valid 2 cycles after IDLE grant (1 per 3 cycles); illegal: valid+err next cycle; losers wait.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int MEM_AW        = MEM_AW_DEF,
   parameter int DATA_BASE     = DATA_BASE_DEF,
   parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int SW = $clog2(MAX_DM_STREAK + 1);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              we_q, we_d;
   logic [2:0]        func3_q, func3_d;
   logic [SW-1:0]     streak_q, streak_d;

   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [2:0]        mem_func3_q, mem_func3_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              if_valid_q, if_valid_d;
   logic              if_err_q, if_err_d;
   logic              dm_valid_q, dm_valid_d;
   logic              dm_err_q, dm_err_d;

   logic              streak_full, dm_win, if_win, if_ok, dm_ok;
   logic [MEM_AW-1:0] dm_mem_addr;
   logic [31:0]       ext_dat;

   assign streak_full = (streak_q == SW'(MAX_DM_STREAK));
   assign dm_win      = bus.dm_req && !(bus.if_req && streak_full);
   assign if_win      = bus.if_req && !dm_win;
   assign if_ok       = is_legal(1'b0, F3_W, bus.if_addr[1:0]);
   assign dm_ok       = is_legal(bus.dm_we, bus.dm_func3, bus.dm_addr[1:0]);
   assign dm_mem_addr = MEM_AW'(bus.dm_addr) + MEM_AW'(DATA_BASE);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      func3_d     = func3_q;
      streak_d    = streak_q;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_func3_d = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if_valid_d  = 1'b0;
      if_err_d    = 1'b0;
      dm_valid_d  = 1'b0;
      dm_err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.if_req) streak_d = '0;
            if (dm_win) begin
               owner_d = OWN_DM;
               we_d    = bus.dm_we;
               func3_d = bus.dm_func3;
               if (bus.if_req && !streak_full) streak_d = streak_q + SW'(1);
               if (dm_ok) begin
                  state_d     = CMD;
                  mem_rd_d    = ~bus.dm_we;
                  mem_wr_d    = bus.dm_we;
                  mem_func3_d = bus.dm_func3;
                  mem_addr_d  = dm_mem_addr;
                  mem_wdata_d = bus.dm_wdata;
               end else begin
                  state_d    = ERR;
                  dm_valid_d = 1'b1;
                  dm_err_d   = 1'b1;
               end
            end else if (if_win) begin
               owner_d  = OWN_IF;
               we_d     = 1'b0;
               func3_d  = F3_W;
               streak_d = '0;
               if (if_ok) begin
                  state_d     = CMD;
                  mem_rd_d    = 1'b1;
                  mem_func3_d = F3_W;
                  mem_addr_d  = MEM_AW'(bus.if_addr);
               end else begin
                  state_d    = ERR;
                  if_valid_d = 1'b1;
                  if_err_d   = 1'b1;
               end
            end
         end
         CMD: begin
            state_d = RESP;
            if (owner_q == OWN_IF) if_valid_d = 1'b1;
            else                   dm_valid_d = 1'b1;
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         func3_q     <= '0;
         streak_q    <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_func3_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_valid_q  <= 1'b0;
         if_err_q    <= 1'b0;
         dm_valid_q  <= 1'b0;
         dm_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         func3_q     <= func3_d;
         streak_q    <= streak_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_func3_q <= mem_func3_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_valid_q  <= if_valid_d;
         if_err_q    <= if_err_d;
         dm_valid_q  <= dm_valid_d;
         dm_err_q    <= dm_err_d;
      end
   end

   // Memory returns data the cycle after mem_rd, i.e. during RESP, so read data is steered, not registered.
   load_extend u_load_extend (
      .raw_i   (bus.mem_rdata),
      .func3_i (func3_q),
      .ext_o   (ext_dat)
   );

   assign bus.if_rdata  = (state_q == RESP && owner_q == OWN_IF) ? bus.mem_rdata : 32'd0;
   assign bus.dm_rdata  = (state_q == RESP && owner_q == OWN_DM && !we_q) ? ext_dat : 32'd0;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_err    = if_err_q;
   assign bus.dm_valid  = dm_valid_q;
   assign bus.dm_err    = dm_err_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_func3 = mem_func3_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, loads/stores, alignment errors, starvation bound, reset abort.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mem_port_arbiter_if #(.ADDR_W(11), .MEM_AW(13)) bus ();

   mem_port_arbiter #(
      .ADDR_W(11), .MEM_AW(13), .DATA_BASE(2048), .MAX_DM_STREAK(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_dm(input logic we, input logic [2:0] f3, input logic [10:0] a,
                         input logic [31:0] wd);
      bus.dm_req   = 1'b1;
      bus.dm_we    = we;
      bus.dm_func3 = f3;
      bus.dm_addr  = a;
      bus.dm_wdata = wd;
   endtask

   // Legal DM access: command in cycle 1, response in cycle 2, idle in cycle 3.
   task automatic dm_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [10:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                            input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
      set_dm(we, f3, a, wd);
      bus.mem_rdata = mrd;
      step();
      chk({tag, ".mem_rd"}, bus.mem_rd, {31'd0, ~we});
      chk({tag, ".mem_wr"}, bus.mem_wr, {31'd0, we});
      chk({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
      chk({tag, ".mem_func3"}, bus.mem_func3, {29'd0, f3});
      chk({tag, ".mem_wdata"}, bus.mem_wdata, wd);
      chk({tag, ".early_valid"}, bus.dm_valid, 32'd0);
      step();
      chk({tag, ".dm_valid"}, bus.dm_valid, 32'd1);
      chk({tag, ".dm_err"}, bus.dm_err, 32'd0);
      chk({tag, ".dm_rdata"}, bus.dm_rdata, exp_rdata);
      chk({tag, ".mem_rd_off"}, bus.mem_rd, 32'd0);
      bus.dm_req = 1'b0;
      step();
      chk({tag, ".idle_valid"}, bus.dm_valid, 32'd0);
   endtask

   task automatic dm_illegal(input string tag, input logic we, input logic [2:0] f3,
                             input logic [10:0] a);
      set_dm(we, f3, a, 32'hA5A5_A5A5);
      bus.mem_rdata = 32'hFFFF_FFFF;
      step();
      chk({tag, ".dm_valid"}, bus.dm_valid, 32'd1);
      chk({tag, ".dm_err"}, bus.dm_err, 32'd1);
      chk({tag, ".dm_rdata"}, bus.dm_rdata, 32'd0);
      chk({tag, ".no_mem"}, {bus.mem_rd, bus.mem_wr}, 32'd0);
      bus.dm_req = 1'b0;
      step();
      chk({tag, ".idle_valid"}, bus.dm_valid, 32'd0);
   endtask

   logic [7:0] order [6];
   int         n;
   string      exp_order;

   initial begin
      rst           = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.dm_func3  = '0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.mem_rdata = '0;
      #1;
      chk("reset.outs", {bus.mem_rd, bus.mem_wr, bus.if_valid, bus.dm_valid, bus.if_err, bus.dm_err},
          32'd0);
      chk("reset.mem_addr", bus.mem_addr, 32'd0);
      step();
      step();
      rst = 1'b0;
      step();
      chk("idle.outs", {bus.mem_rd, bus.mem_wr, bus.if_valid, bus.dm_valid}, 32'd0);

      // Fetch of a word at 0x010.
      bus.if_req    = 1'b1;
      bus.if_addr   = 11'h010;
      bus.mem_rdata = 32'h00A0_0093;
      step();
      chk("if.mem_rd", bus.mem_rd, 32'd1);
      chk("if.mem_addr", bus.mem_addr, 32'h010);
      chk("if.mem_func3", bus.mem_func3, 32'd2);
      chk("if.early_valid", bus.if_valid, 32'd0);
      step();
      chk("if.valid", bus.if_valid, 32'd1);
      chk("if.err", bus.if_err, 32'd0);
      chk("if.rdata", bus.if_rdata, 32'h00A0_0093);
      bus.if_req = 1'b0;
      step();
      chk("if.idle_valid", bus.if_valid, 32'd0);

      dm_access("lw",    1'b0, 3'b010, 11'h004, 32'h0, 32'hFFFF_FF76, 32'h804, 32'hFFFF_FF76);
      dm_access("lb",    1'b0, 3'b000, 11'h000, 32'h0, 32'h0000_00FA, 32'h800, 32'hFFFF_FFFA);
      dm_access("lbu",   1'b0, 3'b100, 11'h000, 32'h0, 32'h0000_00FA, 32'h800, 32'h0000_00FA);
      dm_access("lh",    1'b0, 3'b001, 11'h002, 32'h0, 32'h1234_8001, 32'h802, 32'hFFFF_8001);
      dm_access("lhu",   1'b0, 3'b101, 11'h002, 32'h0, 32'h1234_8001, 32'h802, 32'h0000_8001);
      dm_access("sh",    1'b1, 3'b001, 11'h008, 32'h1234_ABCD, 32'hDEAD_BEEF, 32'h808, 32'h0);
      dm_access("lw_top", 1'b0, 3'b010, 11'h7FC, 32'h0, 32'h0BAD_F00D, 32'hFFC, 32'h0BAD_F00D);

      dm_illegal("lw_mis", 1'b0, 3'b010, 11'h006);
      dm_illegal("lh_mis", 1'b0, 3'b001, 11'h003);
      dm_illegal("ld_f3",  1'b0, 3'b011, 11'h000);
      dm_illegal("st_f3",  1'b1, 3'b100, 11'h000);

      // Misaligned fetch.
      bus.if_req  = 1'b1;
      bus.if_addr = 11'h012;
      step();
      chk("if_mis.valid", bus.if_valid, 32'd1);
      chk("if_mis.err", bus.if_err, 32'd1);
      chk("if_mis.no_mem", bus.mem_rd, 32'd0);
      chk("if_mis.rdata", bus.if_rdata, 32'd0);
      bus.if_req = 1'b0;
      step();

      // Both requesters held: DM may win four times in a row, then IF must be served.
      bus.if_req    = 1'b1;
      bus.if_addr   = 11'h020;
      set_dm(1'b0, 3'b010, 11'h000, 32'h0);
      bus.mem_rdata = 32'h0000_0011;
      n = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         step();
         if (bus.if_valid)      begin order[n] = "I"; n++; end
         else if (bus.dm_valid) begin order[n] = "D"; n++; end
      end
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      step();
      chk("starve.count", n, 32'd6);
      exp_order = "DDDDID";
      for (int i = 0; i < 6; i++)
         chk($sformatf("starve.grant%0d", i), (i < n) ? {24'd0, order[i]} : 32'd0,
             {24'd0, exp_order[i]});

      // Reset while a fetch is in CMD: command drops at once, no response, then a clean retry.
      bus.if_req    = 1'b1;
      bus.if_addr   = 11'h040;
      bus.mem_rdata = 32'hCAFE_F00D;
      step();
      chk("rst.cmd_seen", bus.mem_rd, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst.mem_rd_async", bus.mem_rd, 32'd0);
      step();
      chk("rst.no_valid", {bus.if_valid, bus.dm_valid}, 32'd0);
      rst = 1'b0;
      step();
      chk("rst.retry_mem_rd", bus.mem_rd, 32'd1);
      chk("rst.retry_addr", bus.mem_addr, 32'h040);
      step();
      chk("rst.retry_valid", bus.if_valid, 32'd1);
      chk("rst.retry_rdata", bus.if_rdata, 32'hCAFE_F00D);
      bus.if_req = 1'b0;
      step();
      chk("rst.retry_idle", bus.if_valid, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
